// File: rtl/linebuf_window3x3.sv
// Streaming 3x3 neighbourhood generator: two line buffers feed a shifting window
// register that is exposed as a registered read port with a one-cycle valid pulse.
module linebuf_window3x3 #(
    parameter int IMG_W = 16,
    parameter int IMG_H = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tstart,
    input  logic [31:0]            pix_in,
    input  logic [2:0][2:0]        rd_en,
    output logic [2:0][2:0][31:0]  rd_data,
    output logic                   tout,
    output logic                   frame_done,
    output logic                   rd_err
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic [CW-1:0]           col_q, col_d;
    logic [RW-1:0]           row_q, row_d;
    logic [31:0]             lb0_q [IMG_W];
    logic [31:0]             lb1_q [IMG_W];
    logic [2:0][2:0][31:0]   win_q, win_d;
    logic                    tout_q, tout_d;
    logic                    fd_q, fd_d;
    logic                    err_q, err_d;
    logic                    last_col, last_row;
    logic [31:0]             lb0_rd, lb1_rd;

    always_comb begin
        last_col = (col_q == CW'(IMG_W - 1));
        last_row = (row_q == RW'(IMG_H - 1));
        lb0_rd   = lb0_q[col_q];
        lb1_rd   = lb1_q[col_q];

        col_d  = col_q;
        row_d  = row_q;
        win_d  = win_q;
        tout_d = 1'b0;
        fd_d   = 1'b0;
        // Enables are only legal while the registered window is flagged valid.
        err_d  = err_q | ((|rd_en) & ~tout_q);

        if (tstart) begin
            for (int unsigned i = 0; i < 3; i++) begin
                win_d[i][0] = win_q[i][1];
                win_d[i][1] = win_q[i][2];
            end
            win_d[0][2] = lb0_rd;
            win_d[1][2] = lb1_rd;
            win_d[2][2] = pix_in;

            tout_d = (row_q >= RW'(2)) && (col_q >= CW'(2));
            fd_d   = last_col && last_row;

            col_d = last_col ? '0 : col_q + CW'(1);
            if (last_col) begin
                row_d = last_row ? '0 : row_q + RW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q  <= '0;
            row_q  <= '0;
            win_q  <= '0;
            tout_q <= 1'b0;
            fd_q   <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            win_q  <= win_d;
            tout_q <= tout_d;
            fd_q   <= fd_d;
            err_q  <= err_d;
        end
    end

    // Line buffers carry no reset; stale entries never reach a valid window.
    always_ff @(posedge clk) begin
        if (tstart && !rst) begin
            lb0_q[col_q] <= lb1_rd;
            lb1_q[col_q] <= pix_in;
        end
    end

    assign rd_data    = win_q;
    assign tout       = tout_q;
    assign frame_done = fd_q;
    assign rd_err     = err_q;

endmodule

// File: doc/linebuf_window3x3.md
# linebuf_window3x3

Streaming 3x3 window provider and the producer side of the 3x3 read-port interface that `weighted_average` consumes. It accepts a raster pixel stream, one pixel per `tstart` pulse, and holds two previous lines in internal buffers. It presents the current 3x3 neighbourhood on a `rd_data[2:0][2:0]` array that is stable and combinationally readable in the cycle a consumer asserts its read enables. It also signals window availability with a one-cycle `tout` pulse, so a consumer's `tstart` can be driven directly from it.

## Interface
- `IMG_W`, 16, pixels per line (≥3)
- `IMG_H`, 16, lines per frame (≥3)
- `clk`  in  1  clock; all state updates on posedge
- `rst`  in  1  synchronous, active-high reset
- `tstart`  in  1  pixel-accept strobe; `pix_in` valid this cycle
- `pix_in`  in  32  pixel value
- `rd_en[2:0][2:0]`  in  1 each  consumer read enables
- `rd_data[2:0][2:0]`  out  32 each  window contents; row 0 is oldest line, column 0 is leftmost
- `tout`  out  1  window-valid pulse
- `frame_done`  out  1  pulse after the last pixel of a frame
- `rd_err`  out  1  sticky protocol error

## Operation
- Counters:
  - `col` runs 0..IMG_W-1 and advances on each accepted pixel.
  - At `col`=IMG_W-1 it wraps to 0 and `row` increments.
  - `row` wraps to 0 after IMG_H-1.
- Line buffers:
  - `lb1` holds line r-1 and `lb0` holds line r-2. Each is IMG_W x 32, indexed by `col`.
  - On accept at (r,c): read `lb0[c]` and `lb1[c]`, then write `lb0[c]`<=`lb1[c]` and `lb1[c]`<=`pix_in`.
- Window register, on accept:
  - Every row shifts left: `win[i][0]`<=`win[i][1]`, `win[i][1]`<=`win[i][2]`.
  - New right column: `win[0][2]`<=`lb0[c]`, `win[1][2]`<=`lb1[c]`, `win[2][2]`<=`pix_in`.
- `rd_data` = `win`, driven continuously from registers. There is no combinational path from `pix_in`.
- Valid window: the pixel accepted at (r,c) with r≥2 and c≥2. There is no border padding, so a frame yields (IMG_H-2)*(IMG_W-2) windows.
- After the valid window for (r,c) is produced, `rd_data[i][j]` = pixel(r-2+i, c-2+j).
- `frame_done`: pulses after accepting (IMG_H-1, IMG_W-1).
- `rd_err`:
  - Sets if any `rd_en` bit is 1 in a cycle where `tout`=0.
  - Cleared only by `rst`.
  - Enables in a `tout` cycle are legal. Partial enable sets are legal.
- No backpressure. The consumer must accept every window in its `tout` cycle.
- Line-buffer contents at line starts are stale. This is harmless because `tout` is gated by c≥2.

## Timing
- Accept at edge N → `win` updated at edge N → `tout`=1 for the cycle between edges N and N+1.
- `rd_data` is stable throughout that cycle, so a consumer registering `rd_data` at edge N+1 captures the window.
- Back-to-back `tstart` (one per cycle) is supported at full throughput.
  - `tout` may stay high for consecutive cycles, each cycle carrying a new window.
- Gaps in `tstart`: state holds and `tout`=0.
- `frame_done` is coincident with the `tout` pulse of the last window, one cycle after the final accept.
- `tstart` in the cycle after `frame_done` is pixel (0,0) of the next frame.
- Reset values:
  - `col`=0, `row`=0.
  - `win` all 0, so `rd_data`=0.
  - `tout`=0, `frame_done`=0, `rd_err`=0.
  - Line buffers are not cleared; their contents are don't-care.
- `rst` mid-frame: the next accepted pixel is (0,0). No `tout` occurs until (2,2) of the new frame.
- `rst` and `tstart` in the same cycle: `rst` wins and the pixel is dropped.

## Test plan
All scenarios use IMG_W=8, IMG_H=4.

- Ramp frame, `pix_in`=r*8+c, continuous `tstart`:
  - Exactly 12 `tout` pulses.
  - First window: `rd_data[0][0]`=0, `[0][2]`=2, `[1][1]`=9, `[2][2]`=18.
  - Last window: `[0][0]`=13, `[2][2]`=31.
  - `frame_done` pulses once, in the same cycle as the 12th `tout`.
- Same ramp with `tstart` every 3rd cycle:
  - Identical window sequence to the continuous case.
  - `tout` only in cycles following an accept.
  - `rd_data` unchanged during gaps.
- Two back-to-back frames, second frame `pix_in`=100+r*8+c:
  - 24 `tout` pulses total.
  - Second frame's first window has `[2][2]`=118 and `[0][0]`=100.
- `tout` wired to `weighted_average` `tstart`, constant image of 16:
  - Every output equals 16.
  - `rd_err` stays 0.
- `rd_en[1][1]`=1 in a cycle with `tout`=0:
  - `rd_err`=1 from the next cycle onward and held across further pixels.
  - Only `rst` returns it to 0.
- `rst` asserted after 13 pixels, then a fresh ramp:
  - All outputs read 0 the cycle after reset.
  - 12 pulses follow, with the first window identical to the first scenario's.
